sw_input_port: RTL and testbench
================================

SW_INPUT_PORT -- requirements
Module: sw_input_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive synchronised cycles needed to accept a strobe level change (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  the single system clock; all flops on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port SW  input  10  raw board switches: SW[7:0] data, SW[8] strobe, SW[9] mode.
REQ-005 SHALL have port data  output  8  captured SW[7:0], held stable while valid=1.
REQ-006 SHALL have port valid  output  1  captured byte available to the processor.
REQ-007 SHALL have port ack  input  1  processor has consumed data; sampled only while valid=1.
REQ-008 SHALL have port mode  output  1  synchronised SW[9], no debounce.
REQ-009 SHALL have port overrun  output  1  sticky flag for a strobe press that was lost.

Function
REQ-010 SHALL pass all 10 SW bits through a two-flop synchroniser (s1, s2) before any other use.
REQ-011 SHALL debounce s2[8] into a register named stable using counter cnt, where cnt is $clog2(DEBOUNCE_CYCLES) bits wide.
REQ-012 Debounce rule: when s2[8]==stable, cnt<=0; otherwise, if cnt==DEBOUNCE_CYCLES-1, stable<=s2[8] and cnt<=0; otherwise cnt<=cnt+1.
REQ-013 Any glitch on s2[8] shorter than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged.
REQ-014 SHALL implement FSM states IDLE, VALID and WAIT_RELEASE.
REQ-015 IDLE -> VALID when stable==1, capturing data<=s2[7:0] and setting valid<=1 on the same edge.
REQ-016 VALID -> WAIT_RELEASE when ack==1, clearing valid<=1'b0 on the same edge; data SHALL hold its value.
REQ-017 WAIT_RELEASE -> IDLE when stable==0.
REQ-018 ack SHALL be ignored in IDLE and WAIT_RELEASE.
REQ-019 Latency: counting the edge that first samples SW[8]=1 into s1 as edge 0, valid SHALL rise at edge DEBOUNCE_CYCLES+2 (edge 18 at the default).
REQ-020 data SHALL NOT change while valid==1, whatever happens on SW[7:0].
REQ-021 Holding the strobe on after ack SHALL produce exactly one capture; a new capture requires a debounced release and then a press.
REQ-022 mode SHALL equal s2[9].

Reset
REQ-023 While reset=1: s1, s2, stable, cnt, data, valid, mode and overrun SHALL be 0, and the state SHALL be IDLE, all asynchronously.
REQ-024 Reset asserted while valid=1 SHALL drop valid immediately and discard the pending byte.
REQ-025 If SW[8] is still high when reset is released, it SHALL be treated as a new press, giving valid DEBOUNCE_CYCLES+2 edges after reset release.

Configuration
REQ-026 Macro SW_PORT_OVERRUN_EN defined: in VALID, a debounced 1->0->1 strobe cycle before ack SHALL set overrun<=1.
REQ-027 With SW_PORT_OVERRUN_EN defined: overrun SHALL clear only on reset, and data SHALL keep the first byte.
REQ-028 Macro SW_PORT_OVERRUN_EN undefined: overrun SHALL be tied to 0 and the tracking logic SHALL not be synthesised; all other behaviour is identical.

Verification
REQ-029 DEBOUNCE_CYCLES=16, SW=0x0A5 then SW[8]=1 held -> valid=1 at edge 18 with data=0xA5, and valid=0 one edge before that.
REQ-030 SW[8] pulse of 10 cycles (stable width < 16) -> valid stays 0 and stable stays 0.
REQ-031 Capture 0x3C, then change SW[7:0] to 0xFF while valid=1, then ack=1 for one cycle -> data stays 0x3C throughout; valid falls on the ack edge; no second capture while SW[8] remains high.
REQ-032 Release strobe, press again with SW[7:0]=0x81, ack -> second capture with data=0x81, overrun=0.
REQ-033 With SW_PORT_OVERRUN_EN defined: capture 0x11, then a debounced release and press with 0x22 before ack -> overrun=1 and data=0x11; reset -> overrun=0.
REQ-034 Assert reset mid-VALID -> valid=0 and data=0 within the same cycle, and the state is IDLE.

Source files
------------

// File: rtl/sw_input_port.sv
// sw_input_port: turns the board switches into a processor input port.
// SW[7:0] is the data byte, SW[8] is the strobe and SW[9] is the mode bit.
// All switch bits pass through a two-flop synchroniser. The strobe is then
// debounced. A small handshake FSM captures one byte per debounced press and
// holds it until the processor acks it.
// Optional feature: define SW_PORT_OVERRUN_EN to build the sticky overrun
// flag. Without it, overrun is tied low and no tracking logic exists.
module sw_input_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] SW,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       mode,
   output logic       overrun
);

   localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned SW_W    = 10;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned STB_BIT = 8;
   localparam int unsigned MOD_BIT = 9;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      VALID        = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   logic [SW_W-1:0]   s1;
   logic [SW_W-1:0]   s2;
   logic              stable;
   logic [CNT_W-1:0]  cnt;
   state_t            state;
   state_t            state_nxt;
   logic              valid_nxt;
   logic [DATA_W-1:0] data_nxt;

   // Two-flop synchroniser for every switch bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= SW;
         s2 <= s1;
      end
   end

   // Mode comes straight from the synchroniser; it is not debounced
   assign mode = s2[MOD_BIT];

   // Strobe debounce: a new level must persist DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (s2[STB_BIT] == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         stable <= s2[STB_BIT];
         cnt    <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Handshake FSM state register and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         valid <= 1'b0;
         data  <= '0;
      end else begin
         state <= state_nxt;
         valid <= valid_nxt;
         data  <= data_nxt;
      end
   end

   // Next state: capture on a debounced press, release valid on ack, then
   // wait for a debounced release before arming again
   always_comb begin
      state_nxt = state;
      valid_nxt = valid;
      data_nxt  = data;
      case (state)
         IDLE: begin
            if (stable) begin
               state_nxt = VALID;
               valid_nxt = 1'b1;
               data_nxt  = s2[DATA_W-1:0];
            end
         end
         VALID: begin
            if (ack) begin
               state_nxt = WAIT_RELEASE;
               valid_nxt = 1'b0;
            end
         end
         WAIT_RELEASE: begin
            if (!stable) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

`ifdef SW_PORT_OVERRUN_EN
   logic rel_seen;
   logic rel_seen_nxt;
   logic overrun_nxt;

   // Overrun tracking registers; overrun is sticky until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rel_seen <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rel_seen <= rel_seen_nxt;
         overrun  <= overrun_nxt;
      end
   end

   // A debounced release followed by a press while a byte is pending is lost
   always_comb begin
      rel_seen_nxt = rel_seen;
      overrun_nxt  = overrun;
      if (state == VALID) begin
         if (!stable) begin
            rel_seen_nxt = 1'b1;
         end else if (rel_seen) begin
            overrun_nxt = 1'b1;
         end
      end else begin
         rel_seen_nxt = 1'b0;
      end
   end
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sw_input_port.sv
// tb_sw_input_port: directed self-checking bench for sw_input_port at the
// default DEBOUNCE_CYCLES=16. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point. So "edge 0" is the first rising edge
// after an input change. Build with SW_PORT_OVERRUN_EN to cover the overrun
// flag.
module tb_sw_input_port;

   localparam int unsigned DC = 16;

   logic       clk;
   logic       reset;
   logic [9:0] SW;
   logic [7:0] data;
   logic       valid;
   logic       ack;
   logic       mode;
   logic       overrun;

   int unsigned n_checks;
   int unsigned n_fail;

   sw_input_port #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk     (clk),
      .reset   (reset),
      .SW      (SW),
      .data    (data),
      .valid   (valid),
      .ack     (ack),
      .mode    (mode),
      .overrun (overrun)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports a mismatch
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and land 1 unit after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Directed stimulus
   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      SW       = 10'h000;
      ack      = 1'b0;
      tick(3);

      // Reset state
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", 32'(data), 32'h00);
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_stable", 32'(dut.stable), 32'd0);
      check("rst_state", 32'(dut.state), 32'd0);
      reset = 1'b0;
      tick(2);

      // Mode follows SW[9] through two flops
      SW = 10'h200;
      tick(1);
      check("mode_lat1", 32'(mode), 32'd0);
      tick(1);
      check("mode_lat2", 32'(mode), 32'd1);
      SW = 10'h000;
      tick(3);
      check("mode_clr", 32'(mode), 32'd0);

      // First press, 0xA5: valid rises exactly at edge DC+2
      SW = 10'h0A5;
      tick(3);
      SW = 10'h1A5;
      tick(DC + 2);
      check("lat_edge17_valid", 32'(valid), 32'd0);
      tick(1);
      check("lat_edge18_valid", 32'(valid), 32'd1);
      check("lat_edge18_data", 32'(data), 32'hA5);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("a5_ack_valid", 32'(valid), 32'd0);
      SW = 10'h000;
      tick(DC + 6);
      check("a5_release_state", 32'(dut.state), 32'd0);

      // Short strobe glitch, 10 cycles: must be rejected
      SW = 10'h100;
      for (int i = 0; i < 40; i++) begin
         if (i == 10) SW = 10'h000;
         tick(1);
         check("glitch_stable", 32'(dut.stable), 32'd0);
         check("glitch_valid", 32'(valid), 32'd0);
      end

      // Capture 0x3C; data must hold while SW[7:0] changes and after ack
      SW = 10'h13C;
      tick(DC + 3);
      check("3c_valid", 32'(valid), 32'd1);
      check("3c_data", 32'(data), 32'h3C);
      SW = 10'h1FF;
      tick(5);
      check("3c_hold_data", 32'(data), 32'h3C);
      check("3c_hold_valid", 32'(valid), 32'd1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("3c_ack_valid", 32'(valid), 32'd0);
      check("3c_ack_data", 32'(data), 32'h3C);
      check("3c_ack_state", 32'(dut.state), 32'd2);
      // Ack in WAIT_RELEASE is ignored; strobe held gives no new capture
      ack = 1'b1;
      tick(3);
      ack = 1'b0;
      tick(DC * 2);
      check("3c_no_recapture", 32'(valid), 32'd0);
      check("3c_held_data", 32'(data), 32'h3C);

      // Release, ack while IDLE (ignored), then press with 0x81
      SW = 10'h081;
      tick(DC + 6);
      check("81_idle_state", 32'(dut.state), 32'd0);
      ack = 1'b1;
      tick(3);
      ack = 1'b0;
      check("81_idle_ack_valid", 32'(valid), 32'd0);
      SW = 10'h181;
      tick(DC + 3);
      check("81_valid", 32'(valid), 32'd1);
      check("81_data", 32'(data), 32'h81);
      check("81_overrun", 32'(overrun), 32'd0);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("81_ack_valid", 32'(valid), 32'd0);
      SW = 10'h000;
      tick(DC + 6);

`ifdef SW_PORT_OVERRUN_EN
      // Release and press again before ack: overrun is set, first byte is kept
      SW = 10'h111;
      tick(DC + 3);
      check("ovr_first_data", 32'(data), 32'h11);
      SW = 10'h022;
      tick(DC + 4);
      check("ovr_mid_valid", 32'(valid), 32'd1);
      check("ovr_mid_flag", 32'(overrun), 32'd0);
      SW = 10'h122;
      tick(DC + 4);
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_data", 32'(data), 32'h11);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("ovr_sticky", 32'(overrun), 32'd1);
      SW = 10'h000;
      tick(DC + 6);
      check("ovr_sticky_idle", 32'(overrun), 32'd1);
      reset = 1'b1;
      #1;
      check("ovr_reset_clear", 32'(overrun), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(2);
`endif

      // Reset mid-VALID clears asynchronously; a held strobe re-arms
      SW = 10'h155;
      tick(DC + 3);
      check("rv_valid", 32'(valid), 32'd1);
      check("rv_data", 32'(data), 32'h55);
      #2;
      reset = 1'b1;
      #1;
      check("rv_async_valid", 32'(valid), 32'd0);
      check("rv_async_data", 32'(data), 32'h00);
      check("rv_async_state", 32'(dut.state), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(DC + 2);
      check("rv_rearm_edge17", 32'(valid), 32'd0);
      tick(1);
      check("rv_rearm_edge18", 32'(valid), 32'd1);
      check("rv_rearm_data", 32'(data), 32'h55);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("rv_ack_valid", 32'(valid), 32'd0);
      SW = 10'h000;
      tick(DC + 6);
      check("final_state", 32'(dut.state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
